// File: rtl/bitrev_reorder_buf.sv
// -----------------------------------------------------------------------------
// bitrev_reorder_buf
//
// Streaming reorder buffer that sits after the R2SDF FFT pipeline. The last
// butterfly stage emits samples in bit-reversed order. This block writes each
// sample at bitrev(arrival count) and reads the bank back in natural order.
// Two ping-pong banks of 2**N complex words let one frame fill while the
// previous frame drains, so the buffer can stream at full rate.
//
// Parameters
//   N  log2 of FFT size (frame = 2**N samples)
//   W  width of each real/imag component (passed through untouched)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   buffer can accept (depends on registers only)
//   in_re      real part, bit-reversed order
//   in_im      imag part, bit-reversed order
//   out_valid  output register holds a valid sample
//   out_ready  downstream accepts
//   out_re     real part, natural order
//   out_im     imag part, natural order
//   out_last   high with sample index 2**N-1 of each frame
//   frame_cnt  frames fully drained, 16-bit wrapping
//              (present only when BITREV_FRAME_CNT_EN is defined)
//
// Configuration macro: BITREV_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module bitrev_reorder_buf #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_last
`ifdef BITREV_FRAME_CNT_EN
    ,
    output logic [15:0]  frame_cnt
`endif
);

    localparam int DEPTH = 1 << N;

    // Mirror index bits: bit j of i lands on bit N-1-j.
    function automatic logic [N-1:0] bitrev(input logic [N-1:0] i);
        logic [N-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            r[N-1-j] = i[j];
        end
        return r;
    endfunction

    // Two banks of complex words, {re, im}. Contents are not reset: every
    // location is rewritten before a bank is marked full.
    logic [2*W-1:0] mem [0:1][0:DEPTH-1];

    logic [N-1:0]   wr_cnt;
    logic [N-1:0]   rd_cnt;
    logic           wr_bank;
    logic           rd_bank;
    logic [1:0]     bank_full;

    logic           wr_en;
    logic           wr_last;
    logic           rd_en;
    logic           rd_last;
    logic [2*W-1:0] rd_data;

    assign in_ready = !bank_full[wr_bank];
    assign wr_en    = in_valid && in_ready;
    assign wr_last  = wr_en && (&wr_cnt);

    // Load the output register whenever the read bank is full and the
    // register is empty or being emptied this cycle.
    assign rd_en    = bank_full[rd_bank] && (!out_valid || out_ready);
    assign rd_last  = rd_en && (&rd_cnt);

    assign rd_data  = mem[rd_bank][rd_cnt];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][bitrev(wr_cnt)] <= {in_re, in_im};
        end
    end

    // Write side. wr_cnt wraps naturally at 2**N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_last) begin
                wr_bank <= !wr_bank;
            end
        end
    end

    // Bank occupancy. A set can only target a bank that is not full and a
    // clear can only target a bank that is full, so a same-cycle set and
    // clear always hit different bits and both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= 2'b00;
        end else begin
            if (wr_last) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (rd_last) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read side and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (rd_en) begin
            out_re    <= rd_data[2*W-1:W];
            out_im    <= rd_data[W-1:0];
            out_valid <= 1'b1;
            out_last  <= &rd_cnt;
            rd_cnt    <= rd_cnt + 1'b1;
            if (rd_last) begin
                rd_bank <= !rd_bank;
            end
        end else if (out_valid && out_ready) begin
            // Sample taken with nothing to replace it; data holds its value.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef BITREV_FRAME_CNT_EN
    // Counts frames whose final sample has left the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (out_valid && out_ready && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Self-checking bench for bitrev_reorder_buf (N=4, W=16). Stimulus pushes the
// expected natural-order frame into a queue; an independent monitor pops and
// compares on every output transfer and checks stability during stalls.
module tb_bitrev_reorder_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_last;
`ifdef BITREV_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    bitrev_reorder_buf #(.N(4), .W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
`ifdef BITREV_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_valid_cyc = -1;
    int first_xfer_cyc = -1;
    int last_xfer_cyc = -1;
    int xfer_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_out = '0;
    logic [32:0] exp_q[$];

    // Hand-computed natural-order read sequence for N=4: output k is input sample brv[k].
    int brv[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: samples on the falling edge, well away from the active edge.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'({out_re, out_im, out_last}), 64'(prev_out));
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: actual re=%0d im=%0d last=%0b expected no output",
                             out_re, out_im, out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'({out_re, out_im, out_last}), 64'(e));
                end
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfer_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_re, out_im, out_last};
        end
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [15:0] re, input logic [15:0] im, output int waits);
        waits = 0;
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        @(negedge clk);
        while (!in_ready && waits < 500) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready=0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic push_frame(input logic [15:0] re_base, input logic [15:0] im_base);
        for (int k = 0; k < 16; k++)
            exp_q.push_back({re_base + 16'(brv[k]), im_base + 16'(brv[k]), k == 15});
    endtask

    task automatic send_frame(input logic [15:0] re_base, input logic [15:0] im_base,
                              input int gap_max, output int waits_total);
        int w;
        waits_total = 0;
        push_frame(re_base, im_base);
        for (int i = 0; i < 16; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(re_base + 16'(i), im_base + 16'(i), w);
            waits_total += w;
        end
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int wsum;
        int k0;
        bit stop;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'({out_re, out_im, out_last}), 64'd0);
`ifdef BITREV_FRAME_CNT_EN
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Single frame, re=i, im=100+i, continuous ready.
        out_ready = 1'b1;
        send_frame(16'd0, 16'd100, 0, w);
        wait_drain(100);

        // Two frames back to back: no backpressure, latency, no bubble.
        first_valid_cyc = -1;
        first_xfer_cyc = -1;
        xfer_cnt = 0;
        send_frame(16'd16, 16'd300, 0, wsum);
        k0 = acc_cyc;
        send_frame(16'd32, 16'd400, 0, w);
        wsum += w;
        wait_drain(100);
        chk("t2_no_backpressure", 64'(wsum), 64'd0);
        chk("t2_first_valid_latency", 64'(first_valid_cyc - k0), 64'd1);
        chk("t2_xfer_count", 64'(xfer_cnt), 64'd32);
        chk("t2_no_bubble", 64'(last_xfer_cyc - first_xfer_cyc), 64'd31);
`ifdef BITREV_FRAME_CNT_EN
        chk("frame_cnt_3", 64'(frame_cnt), 64'd3);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt;
        @(negedge clk);
        chk("frame_cnt_preload", 64'(frame_cnt), 64'hFFFF);
        @(posedge clk);
        #1;
`endif

        // Downstream stalled: both banks fill, then drain frame 0.
        out_ready = 1'b0;
        send_frame(16'd48, 16'd500, 0, w);
        send_frame(16'd64, 16'd600, 0, w);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t3_full_in_ready", 64'(in_ready), 64'd0);
        chk("t3_full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("t3_in_ready_before_16th", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t3_in_ready_after_16th", 64'(in_ready), 64'd1);
        wait_drain(100);
`ifdef BITREV_FRAME_CNT_EN
        chk("frame_cnt_wrap", 64'(frame_cnt), 64'd1);
`endif

        // Random gaps on both sides over 8 frames.
        stop = 1'b0;
        fork
            begin
                for (int f = 0; f < 8; f++)
                    send_frame(16'(16'h1000 + f * 256), 16'(16'h8000 + f * 256), 2, w);
                wait_drain(2000);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(100);

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send(16'(16'h7700 + i), 16'(16'h7800 + i), w);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", 64'({out_re, out_im, out_last}), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef BITREV_FRAME_CNT_EN
        @(negedge clk);
        chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(posedge clk);
        #1;
`endif
        xfer_cnt = 0;
        send_frame(16'd50, 16'd200, 0, w);
        wait_drain(100);
        chk("post_rst_xfer_count", 64'(xfer_cnt), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
